// File: rtl/wordgen_seq.sv
// wordgen_seq: captures switch words into a circular store and serialises them on one pin
// as framed bit streams (start bit, MSB-first data, low gap), per write or in rotation.
module wordgen_seq #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int BIT_DIV = 50,
  parameter int GAP     = 2
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           sw,
  input  logic                       write,
  input  logic                       auto,
  output logic                       out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TMR_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BC_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int BC_W   = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;

  state_t           state, state_n;
  logic             wr_s1, wr_s2, wr_s3, au_s1, au_s2;
  logic             wr_evt, auto_s, bit_end;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr, pend_idx, cur_idx_n, start_idx;
  logic             pending, start_frame, take_wr, out_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] idx_inc;

  assign wr_evt  = wr_s2 & ~wr_s3;
  assign auto_s  = au_s2;
  assign bit_end = (timer == TMR_W'(BIT_DIV - 1));
  assign idx_inc = CNT_W'(cur_idx) + CNT_W'(1);

  always_comb begin
    state_n     = state;
    timer_n     = bit_end ? '0 : timer + TMR_W'(1);
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    cur_idx_n   = cur_idx;
    start_frame = 1'b0;
    start_idx   = cur_idx;
    take_wr     = 1'b0;
    out_n       = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (auto_s) begin
          if (count != '0) begin
            start_frame = 1'b1;
            start_idx   = '0;
          end
        end else if (pending) begin
          start_frame = 1'b1;
          start_idx   = pend_idx;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_cnt_n = BC_W'(WIDTH - 1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = shreg << 1;
          if (bit_cnt == '0) begin
            state_n   = S_GAP;
            bit_cnt_n = BC_W'(GAP - 1);
          end else begin
            bit_cnt_n = bit_cnt - BC_W'(1);
          end
        end
      end
      S_GAP: begin
        // A write landing on the last gap cycle is sent next, with no idle cycle.
        if (bit_end) begin
          if (bit_cnt != '0) begin
            bit_cnt_n = bit_cnt - BC_W'(1);
          end else if (auto_s) begin
            start_frame = 1'b1;
            start_idx   = (idx_inc == count) ? '0 : IDX_W'(idx_inc);
          end else if (wr_evt) begin
            start_frame = 1'b1;
            take_wr     = 1'b1;
            start_idx   = wr_ptr;
          end else if (pending) begin
            start_frame = 1'b1;
            start_idx   = pend_idx;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (start_frame) begin
      state_n   = S_START;
      timer_n   = '0;
      cur_idx_n = start_idx;
      // Bypass the store when the selected entry is being written on this same edge.
      shreg_n   = (wr_evt && wr_ptr == start_idx) ? sw : mem[start_idx];
    end
    if (state_n == S_START)     out_n = 1'b1;
    else if (state_n == S_DATA) out_n = shreg_n[WIDTH-1];
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= S_IDLE;
      {wr_s1, wr_s2, wr_s3, au_s1, au_s2} <= '0;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cur_idx  <= '0;
      wr_ptr   <= '0;
      pend_idx <= '0;
      pending  <= 1'b0;
      count    <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_s1   <= write;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      au_s1   <= auto;
      au_s2   <= au_s1;
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      cur_idx <= cur_idx_n;
      out     <= out_n;
      busy    <= (state_n != S_IDLE);
      if (wr_evt) begin
        wr_ptr   <= wr_ptr + IDX_W'(1);
        pend_idx <= wr_ptr;
        if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
      end
      if (auto_s)                  pending <= 1'b0;
      else if (wr_evt && !take_wr) pending <= 1'b1;
      else if (start_frame)        pending <= 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_evt && !reset) mem[wr_ptr] <= sw;
  end
endmodule

// File: tb/tb_wordgen_seq.sv
// Bench for wordgen_seq: scheduled stimulus, per-cycle sampling, and a frame-level
// reference model that predicts every output waveform from write/auto event times.
module tb_wordgen_seq;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int BD = 4;
  localparam int G  = 2;
  localparam int FL = (1 + W + G) * BD;
  localparam int NS = 4000;

  logic         sysclk = 1'b0;
  logic         reset, write, auto, out, busy;
  logic [W-1:0] sw;
  logic [2:0]   count;
  logic [1:0]   cur_idx;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  logic       s_out [NS];
  logic       s_busy[NS];
  logic [2:0] s_cnt [NS];
  logic [1:0] s_idx [NS];

  int           ev_c[$];
  int           ev_k[$];
  int           ev_v[$];
  int           wt[$];
  logic [W-1:0] ww[$];
  int           f_start[$];
  logic [W-1:0] f_word[$];
  int           f_idx[$];

  logic [W-1:0] m_mem[D];
  int           m_ptr = 0;
  int           m_cnt = 0;

  wordgen_seq #(.WIDTH(W), .DEPTH(D), .BIT_DIV(BD), .GAP(G)) dut (
    .sysclk(sysclk), .reset(reset), .sw(sw), .write(write), .auto(auto),
    .out(out), .busy(busy), .count(count), .cur_idx(cur_idx)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #60000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  function automatic int m_write(logic [W-1:0] v);
    int i;
    i = m_ptr;
    m_mem[m_ptr] = v;
    m_ptr = (m_ptr + 1) % D;
    if (m_cnt < D) m_cnt++;
    return i;
  endfunction

  function automatic void m_clear();
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic void add_frame(int s, logic [W-1:0] w, int i);
    f_start.push_back(s);
    f_word.push_back(w);
    f_idx.push_back(i);
  endfunction

  function automatic void clear_frames();
    f_start.delete();
    f_word.delete();
    f_idx.delete();
  endfunction

  function automatic logic exp_out(int c);
    for (int i = 0; i < f_start.size(); i++) begin
      if (c >= f_start[i] && c < f_start[i] + FL) begin
        int p;
        logic [W-1:0] wd;
        p  = (c - f_start[i]) / BD;
        wd = f_word[i];
        if (p == 0) return 1'b1;
        if (p <= W) return wd[W-p];
        return 1'b0;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic exp_busy(int c);
    for (int i = 0; i < f_start.size(); i++)
      if (c >= f_start[i] && c < f_start[i] + FL) return 1'b1;
    return 1'b0;
  endfunction

  // kind: 0 write rise with word, 1 write fall, 2 auto level, 3 reset level
  task automatic sched(int c, int k, int v);
    ev_c.push_back(c);
    ev_k.push_back(k);
    ev_v.push_back(v);
  endtask

  task automatic run_to(int endc);
    if (endc >= NS) begin
      $display("FAIL run_to cyc=%0d required<%0d", endc, NS);
      $fatal(1);
    end
    while (cyc < endc) begin
      @(posedge sysclk);
      #1;
      s_out[cyc]  = out;
      s_busy[cyc] = busy;
      s_cnt[cyc]  = count;
      s_idx[cyc]  = cur_idx;
      for (int i = 0; i < ev_c.size(); i++) begin
        if (ev_c[i] == cyc) begin
          case (ev_k[i])
            0: begin sw = W'(ev_v[i]); write = 1'b1; sched(cyc + 2, 1, 0); end
            1: write = 1'b0;
            2: auto  = (ev_v[i] != 0);
            default: reset = (ev_v[i] != 0);
          endcase
        end
      end
    end
  endtask

  // Manual-mode frame schedule: a write reaching the FSM (3 edges after it is driven)
  // starts a frame on the next edge if idle, exactly at the end edge of a running frame,
  // or otherwise replaces the single queued frame that follows the running one.
  task automatic plan_manual();
    int cur_end;
    int qi;
    int idx[$];
    cur_end = -1000;
    qi = -1;
    clear_frames();
    for (int i = 0; i < wt.size(); i++) begin
      int e;
      e = wt[i] + 3;
      idx.push_back(m_write(ww[i]));
      sched(wt[i], 0, int'(ww[i]));
      if (qi >= 0 && cur_end < e) begin
        add_frame(cur_end, ww[qi], idx[qi]);
        cur_end += FL;
        qi = -1;
      end
      if (e < cur_end) begin
        qi = i;
      end else begin
        int s;
        s = (e == cur_end) ? e : e + 1;
        add_frame(s, ww[i], idx[i]);
        cur_end = s + FL;
        qi = -1;
      end
    end
    if (qi >= 0) add_frame(cur_end, ww[qi], idx[qi]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    run_to(cyc + 2);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    run_to(3);
    reset = 1'b0;
    vec++; if (s_out[3] !== 1'b0) begin errs++; $display("FAIL reset_out got=%b exp=0", s_out[3]); end
    vec++; if (s_busy[3] !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", s_busy[3]); end
    vec++; if (s_cnt[3] !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", s_cnt[3]); end
    vec++; if (s_idx[3] !== 2'd0) begin errs++; $display("FAIL reset_cur_idx got=%0d exp=0", s_idx[3]); end
    run_to(cyc + 100);
    for (int c = 4; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c], s_cnt[c]} !== 5'b0) begin
        errs++;
        $display("FAIL idle_quiet cyc=%0d got out=%b busy=%b count=%0d exp all 0", c, s_out[c], s_busy[c], s_cnt[c]);
      end
    end
  endtask

  task automatic test_manual_single();
    for (int rep = 0; rep < 3; rep++) begin
      int b;
      b = cyc + 2;
      wt.delete(); ww.delete();
      wt.push_back(b);
      ww.push_back((rep == 0) ? 4'b1010 : W'($urandom));
      plan_manual();
      run_to(f_start[$] + FL + 6);
      for (int c = b; c <= cyc; c++) begin
        vec++;
        if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
          errs++;
          $display("FAIL single_wave cyc=%0d got out=%b busy=%b exp out=%b busy=%b", c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
        end
      end
      vec++;
      if (int'(s_idx[f_start[0]]) != f_idx[0]) begin
        errs++; $display("FAIL single_cur_idx got=%0d exp=%0d", s_idx[f_start[0]], f_idx[0]);
      end
      vec++;
      if (int'(s_cnt[cyc]) != m_cnt) begin
        errs++; $display("FAIL single_count got=%0d exp=%0d", s_cnt[cyc], m_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int sc = 0; sc < 4; sc++) begin
      int b;
      int r1;
      int r2;
      b  = cyc + 2;
      r1 = $urandom_range(0, 5);
      r2 = $urandom_range(0, 8);
      wt.delete(); ww.delete();
      case (sc)
        0: begin wt = '{b, b + 5}; ww = '{4'h9, 4'h6}; end
        1: begin
          wt = '{b, b + 5 + r1, b + 8 + r1 + r2};
          ww = '{W'($urandom), W'($urandom), W'($urandom)};
        end
        2: begin wt = '{b, b + FL - 3}; ww = '{W'($urandom), W'($urandom)}; end
        default: begin wt = '{b, b + FL - 2}; ww = '{W'($urandom), W'($urandom)}; end
      endcase
      plan_manual();
      run_to(f_start[$] + FL + 6);
      for (int c = b; c <= cyc; c++) begin
        vec++;
        if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
          errs++;
          $display("FAIL b2b_wave sc=%0d cyc=%0d got out=%b busy=%b exp out=%b busy=%b", sc, c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
        end
      end
      for (int i = 0; i < f_start.size(); i++) begin
        vec++;
        if (int'(s_idx[f_start[i]]) != f_idx[i]) begin
          errs++; $display("FAIL b2b_cur_idx sc=%0d frame=%0d got=%0d exp=%0d", sc, i, s_idx[f_start[i]], f_idx[i]);
        end
      end
      vec++;
      if (int'(s_cnt[cyc]) != m_cnt) begin
        errs++; $display("FAIL b2b_count sc=%0d got=%0d exp=%0d", sc, s_cnt[cyc], m_cnt);
      end
    end
  endtask

  task automatic test_auto_rotation();
    int b;
    int a;
    int n;
    pulse_reset();
    b = cyc + 2;
    wt = '{b, b + 4, b + 8};
    ww = '{4'h1, 4'h2, 4'h3};
    plan_manual();
    run_to(f_start[$] + FL + 4);
    for (int c = b; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
        errs++;
        $display("FAIL auto_pre_wave cyc=%0d got out=%b busy=%b exp out=%b busy=%b", c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
      end
    end
    a = cyc + 1;
    n = $urandom_range(4, 6);
    clear_frames();
    for (int i = 0; i < n; i++) add_frame(a + 3 + i * FL, m_mem[i % m_cnt], i % m_cnt);
    sched(a, 2, 1);
    sched(a + 3 + (n - 1) * FL + 10, 2, 0);
    run_to(a + 3 + n * FL + 20);
    for (int c = a; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
        errs++;
        $display("FAIL auto_wave cyc=%0d got out=%b busy=%b exp out=%b busy=%b", c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
      end
    end
    for (int i = 0; i < n; i++) begin
      vec++;
      if (int'(s_idx[f_start[i]]) != f_idx[i]) begin
        errs++; $display("FAIL auto_cur_idx frame=%0d got=%0d exp=%0d", i, s_idx[f_start[i]], f_idx[i]);
      end
    end
    vec++;
    if (int'(s_idx[cyc]) != f_idx[$]) begin
      errs++; $display("FAIL auto_last_idx got=%0d exp=%0d", s_idx[cyc], f_idx[$]);
    end
    vec++;
    if (s_cnt[cyc] !== 3'd3) begin
      errs++; $display("FAIL auto_count got=%0d exp=3", s_cnt[cyc]);
    end
  endtask

  task automatic test_full_overwrite();
    int b;
    int a;
    logic [W-1:0] x;
    pulse_reset();
    b = cyc + 2;
    wt = '{b, b + 4, b + 8, b + 12, b + 16};
    ww = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    plan_manual();
    run_to(f_start[$] + FL + 4);
    for (int c = b; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
        errs++;
        $display("FAIL full_pre_wave cyc=%0d got out=%b busy=%b exp out=%b busy=%b", c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
      end
    end
    vec++;
    if (s_cnt[cyc] !== 3'd4) begin
      errs++; $display("FAIL full_count_sat got=%0d exp=4", s_cnt[cyc]);
    end
    a = cyc + 1;
    clear_frames();
    for (int i = 0; i < 5; i++) add_frame(a + 3 + i * FL, m_mem[i % D], i % D);
    // Overwrite the entry of the frame in flight; the frame keeps its latched word.
    x = W'($urandom);
    sched(f_start[1] + 6, 0, int'(x));
    void'(m_write(x));
    sched(a, 2, 1);
    sched(f_start[4] + 10, 2, 0);
    run_to(f_start[4] + FL + 20);
    for (int c = a; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c]} !== {exp_out(c), exp_busy(c)}) begin
        errs++;
        $display("FAIL full_wave cyc=%0d got out=%b busy=%b exp out=%b busy=%b", c, s_out[c], s_busy[c], exp_out(c), exp_busy(c));
      end
    end
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (int'(s_idx[f_start[i]]) != f_idx[i]) begin
        errs++; $display("FAIL full_cur_idx frame=%0d got=%0d exp=%0d", i, s_idx[f_start[i]], f_idx[i]);
      end
    end
    vec++;
    if (s_cnt[cyc] !== 3'd4) begin
      errs++; $display("FAIL full_count got=%0d exp=4", s_cnt[cyc]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b;
    b = cyc + 2;
    wt = '{b};
    ww = '{W'($urandom)};
    plan_manual();
    sched(b + 10, 3, 1);
    sched(b + 11, 3, 0);
    run_to(b + 11);
    vec++;
    if (int'(s_idx[b + 4]) != f_idx[0]) begin
      errs++; $display("FAIL midrst_pre_idx got=%0d exp=%0d", s_idx[b + 4], f_idx[0]);
    end
    vec++; if (s_out[b + 11] !== 1'b0) begin errs++; $display("FAIL midrst_out got=%b exp=0", s_out[b + 11]); end
    vec++; if (s_busy[b + 11] !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b exp=0", s_busy[b + 11]); end
    vec++; if (s_cnt[b + 11] !== 3'd0) begin errs++; $display("FAIL midrst_count got=%0d exp=0", s_cnt[b + 11]); end
    vec++; if (s_idx[b + 11] !== 2'd0) begin errs++; $display("FAIL midrst_cur_idx got=%0d exp=0", s_idx[b + 11]); end
    m_clear();
    sched(b + 13, 2, 1);
    run_to(b + 73);
    for (int c = b + 12; c <= cyc; c++) begin
      vec++;
      if ({s_out[c], s_busy[c], s_cnt[c]} !== 5'b0) begin
        errs++;
        $display("FAIL empty_auto cyc=%0d got out=%b busy=%b count=%0d exp all 0", c, s_out[c], s_busy[c], s_cnt[c]);
      end
    end
    sched(cyc + 1, 2, 0);
    run_to(cyc + 3);
  endtask

  initial begin
    reset = 1'b1;
    write = 1'b0;
    auto  = 1'b0;
    sw    = '0;
    test_reset();
    test_manual_single();
    test_back_to_back();
    test_auto_rotation();
    test_full_overwrite();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
